// File: rtl/vgachargen_scroll_ctrl_if.sv
// rtl/vgachargen_scroll_ctrl_if.sv - command, host and map port bundle for the scroll controller

interface vgachargen_scroll_ctrl_if #(
  parameter int AW = 12
);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_op_i;
  logic [4:0]    cmd_lines_i;
  logic [7:0]    cmd_ch_i;
  logic [7:0]    cmd_col_i;
  logic          busy_o;
  logic          done_o;
  logic          host_req_i;
  logic          host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [7:0]    host_ch_i;
  logic [7:0]    host_col_i;
  logic          host_gnt_o;
  logic          host_rvalid_o;
  logic [7:0]    host_ch_o;
  logic [7:0]    host_col_o;
  logic [AW-1:0] map_addr_o;
  logic          map_wen_o;
  logic [7:0]    map_ch_o;
  logic [7:0]    map_col_o;
  logic [7:0]    map_ch_i;
  logic [7:0]    map_col_i;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_lines_i, cmd_ch_i, cmd_col_i,
    input  host_req_i, host_we_i, host_addr_i, host_ch_i, host_col_i,
    input  map_ch_i, map_col_i,
    output cmd_ready_o, busy_o, done_o,
    output host_gnt_o, host_rvalid_o, host_ch_o, host_col_o,
    output map_addr_o, map_wen_o, map_ch_o, map_col_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_lines_i, cmd_ch_i, cmd_col_i,
    output host_req_i, host_we_i, host_addr_i, host_ch_i, host_col_i,
    output map_ch_i, map_col_i,
    input  cmd_ready_o, busy_o, done_o,
    input  host_gnt_o, host_rvalid_o, host_ch_o, host_col_o,
    input  map_addr_o, map_wen_o, map_ch_o, map_col_o
  );
endinterface

// File: rtl/vgachargen_scroll_ctrl.sv
// rtl/vgachargen_scroll_ctrl.sv - clear/scroll-up sequencer and host arbiter for the text map port

module vgachargen_scroll_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int AW   = 12
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  vgachargen_scroll_ctrl_if.slave bus
);

  localparam int            TOTAL = COLS * ROWS;
  localparam logic [AW-1:0] LAST  = AW'(TOTAL - 1);

  typedef enum logic [2:0] {
    IDLE,
    COPY_RD,
    COPY_WR,
    FILL,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, dst_q, copy_last_q;
  logic [7:0]    fill_ch_q, fill_col_q;
  logic          rvalid_q;

  logic          host_gnt;
  logic          lines_clamp;
  logic [AW-1:0] shift_cells;
  logic [AW-1:0] map_addr;
  logic          map_wen;
  logic [7:0]    map_ch, map_col;

  // N >= ROWS degenerates to a clear, so the product only ever sees 0..ROWS-1
  assign lines_clamp = (32'(bus.cmd_lines_i) >= ROWS);
  assign shift_cells = lines_clamp ? '0 : AW'(32'(bus.cmd_lines_i) * COLS);

  // The read in COPY_RD and its write in COPY_WR must not be split by a host cycle
  assign host_gnt = bus.host_req_i && (state_q != COPY_WR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          if (!bus.cmd_op_i || lines_clamp) state_d = FILL;
          else if (bus.cmd_lines_i == 5'd0) state_d = DONE;
          else                               state_d = COPY_RD;
        end
      end
      COPY_RD: if (!host_gnt) state_d = COPY_WR;
      COPY_WR: state_d = (dst_q == copy_last_q) ? FILL : COPY_RD;
      FILL:    if (!host_gnt && (dst_q == LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    map_addr = '0;
    map_wen  = 1'b0;
    map_ch   = 8'h00;
    map_col  = 8'h00;
    if (host_gnt) begin
      map_addr = bus.host_addr_i;
      map_wen  = bus.host_we_i;
      if (bus.host_we_i) begin
        map_ch  = bus.host_ch_i;
        map_col = bus.host_col_i;
      end
    end else begin
      case (state_q)
        COPY_RD: map_addr = src_q;
        COPY_WR: begin
          map_addr = dst_q;
          map_wen  = 1'b1;
          map_ch   = bus.map_ch_i;
          map_col  = bus.map_col_i;
        end
        FILL: begin
          map_addr = dst_q;
          map_wen  = 1'b1;
          map_ch   = fill_ch_q;
          map_col  = fill_col_q;
        end
        default: ;
      endcase
    end
  end

  // dst_q doubles as the fill pointer: the copy phase ends exactly where the fill begins
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      copy_last_q <= '0;
      fill_ch_q   <= 8'h00;
      fill_col_q  <= 8'h00;
      rvalid_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= host_gnt && !bus.host_we_i;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            fill_ch_q   <= bus.cmd_ch_i;
            fill_col_q  <= bus.cmd_col_i;
            dst_q       <= '0;
            src_q       <= shift_cells;
            copy_last_q <= LAST - shift_cells;
          end
        end
        COPY_WR: begin
          src_q <= src_q + AW'(1);
          dst_q <= dst_q + AW'(1);
        end
        FILL: if (!host_gnt) dst_q <= dst_q + AW'(1);
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready_o   = (state_q == IDLE);
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.done_o        = (state_q == DONE);
  assign bus.host_gnt_o    = host_gnt;
  assign bus.host_rvalid_o = rvalid_q;
  assign bus.host_ch_o     = rvalid_q ? bus.map_ch_i  : 8'h00;
  assign bus.host_col_o    = rvalid_q ? bus.map_col_i : 8'h00;
  assign bus.map_addr_o    = map_addr;
  assign bus.map_wen_o     = map_wen;
  assign bus.map_ch_o      = map_ch;
  assign bus.map_col_o     = map_col;

endmodule

// File: tb/tb_vgachargen_scroll_ctrl.sv
// tb/tb_vgachargen_scroll_ctrl.sv - scoreboard bench for the clear/scroll sequencer

module tb_vgachargen_scroll_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int AW    = 12;
  localparam int TOTAL = COLS * ROWS;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vgachargen_scroll_ctrl_if #(.AW(AW)) bus ();

  vgachargen_scroll_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  logic [15:0] mem [4096];
  logic [15:0] exp_map [TOTAL];
  logic [15:0] rd_q_data;
  logic        preload = 1'b0;

  function automatic logic [15:0] preload_val(int k);
    logic [11:0] kk;
    kk = 12'(k);
    return {kk[7:0], 4'h0, kk[11:8]};
  endfunction

  // Synchronous map RAM: read data appears the cycle after the address
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < TOTAL; k++) mem[k] <= preload_val(k);
    end else if (bus.map_wen_o) begin
      mem[bus.map_addr_o] <= {bus.map_ch_o, bus.map_col_o};
    end
    rd_q_data <= mem[bus.map_addr_o];
  end
  assign bus.map_ch_i  = rd_q_data[15:8];
  assign bus.map_col_i = rd_q_data[7:0];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [27:0] wr_q [$];
  logic [15:0] rd_q [$];
  int busy_cycles = 0;
  int stall_cycles = 0;
  int done_cycles = 0;
  int n_writes = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.host_rvalid_o) begin
        check("rvalid_expected", 32'(rd_q.size() > 0), 1);
        if (rd_q.size() > 0) check("host_rdata", {bus.host_ch_o, bus.host_col_o}, rd_q.pop_front());
      end
      if (bus.host_gnt_o) begin
        check("gnt_addr", 32'(bus.map_addr_o), 32'(bus.host_addr_i));
        if (!bus.host_we_i) rd_q.push_back(mem[bus.map_addr_o]);
      end
      if (bus.map_wen_o) begin
        n_writes++;
        if (!bus.host_we_i) begin
          check("no_gnt_on_engine_write", 32'(bus.host_gnt_o), 0);
          check("write_expected", 32'(wr_q.size() > 0), 1);
          if (wr_q.size() > 0)
            check("map_write", {bus.map_addr_o, bus.map_ch_o, bus.map_col_o}, wr_q.pop_front());
        end
      end
      if (bus.busy_o) busy_cycles++;
      if (bus.busy_o && bus.host_gnt_o && !bus.done_o) stall_cycles++;
      if (bus.done_o) done_cycles++;
    end
  end

  task automatic push_wr(int a, logic [15:0] d);
    wr_q.push_back({12'(a), d});
    exp_map[a] = d;
  endtask

  // Queue the write stream the command must produce and return its unstalled duration
  task automatic plan_cmd(logic op, int lines, logic [7:0] ch, logic [7:0] col, output int dur);
    if (!op || lines >= ROWS) begin
      for (int k = 0; k < TOTAL; k++) push_wr(k, {ch, col});
      dur = TOTAL + 1;
    end else if (lines == 0) begin
      dur = 1;
    end else begin
      for (int k = 0; k < TOTAL - lines * COLS; k++) push_wr(k, exp_map[k + lines * COLS]);
      for (int k = TOTAL - lines * COLS; k < TOTAL; k++) push_wr(k, {ch, col});
      dur = 2 * COLS * (ROWS - lines) + COLS * lines + 1;
    end
  endtask

  task automatic accept_cmd(logic op, int lines, logic [7:0] ch, logic [7:0] col);
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_lines_i = 5'(lines);
    bus.cmd_ch_i    = ch;
    bus.cmd_col_i   = col;
    @(negedge clk);
    check("cmd_ready_idle", 32'(bus.cmd_ready_o), 1);
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    busy_cycles  = 0;
    stall_cycles = 0;
    done_cycles  = 0;
  endtask

  task automatic run_cmd(string tag, logic op, int lines, logic [7:0] ch, logic [7:0] col, bit host_mode);
    int dur;
    int w0;
    bit seen;
    plan_cmd(op, lines, ch, col, dur);
    w0 = n_writes;
    accept_cmd(op, lines, ch, col);
    seen = 0;
    for (int c = 0; c < dur + 6000 && !seen; c++) begin
      bus.host_req_i  = host_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.host_addr_i = 12'($urandom_range(0, TOTAL - 1));
      @(negedge clk);
      if (c == 0) begin
        check({tag, "_ready_low"}, 32'(bus.cmd_ready_o), 0);
        check({tag, "_busy_high"}, 32'(bus.busy_o), 1);
      end
      if (bus.done_o) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
    @(posedge clk); #1;
    bus.host_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_duration"}, 32'(busy_cycles), 32'(dur + stall_cycles));
    check({tag, "_done_pulse"}, 32'(done_cycles), 1);
    check({tag, "_writes_left"}, 32'(wr_q.size()), 0);
    check({tag, "_reads_left"}, 32'(rd_q.size()), 0);
    check({tag, "_ready_after"}, 32'(bus.cmd_ready_o), 1);
    if (lines == 0 && op) check({tag, "_no_writes"}, 32'(n_writes - w0), 0);
  endtask

  task automatic do_preload();
    for (int k = 0; k < TOTAL; k++) exp_map[k] = preload_val(k);
    @(posedge clk); #1;
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
  endtask

  initial begin
    int errs;
    int w_snap;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = 1'b0;
    bus.cmd_lines_i = 5'd0;
    bus.cmd_ch_i    = 8'h00;
    bus.cmd_col_i   = 8'h00;
    bus.host_req_i  = 1'b0;
    bus.host_we_i   = 1'b0;
    bus.host_addr_i = '0;
    bus.host_ch_i   = 8'h00;
    bus.host_col_i  = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready_o), 1);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_done", 32'(bus.done_o), 0);
    check("rst_rvalid", 32'(bus.host_rvalid_o), 0);
    check("rst_wen", 32'(bus.map_wen_o), 0);
    check("rst_addr", 32'(bus.map_addr_o), 0);
    check("rst_wdata", {bus.map_ch_o, bus.map_col_o}, 0);
    check("rst_rdata", {bus.host_ch_o, bus.host_col_o}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    run_cmd("clear", 1'b0, 0, 8'h20, 8'h0F, 1'b0);

    do_preload();
    run_cmd("scroll1", 1'b1, 1, 8'h00, 8'h07, 1'b0);
    check("scroll1_cell0", 32'(mem[0]), 32'(preload_val(80)));
    check("scroll1_cell2319", 32'(mem[2319]), 32'(preload_val(2399)));
    check("scroll1_cell2320", 32'(mem[2320]), 32'h0007);

    run_cmd("scroll0", 1'b1, 0, 8'h55, 8'hAA, 1'b0);
    run_cmd("scroll31", 1'b1, 31, 8'h41, 8'h1E, 1'b0);

    do_preload();
    run_cmd("scroll29_host", 1'b1, 29, 8'h2E, 8'h70, 1'b1);
    errs = 0;
    for (int k = 0; k < TOTAL; k++) if (mem[k] !== exp_map[k]) errs++;
    check("scroll29_final_map", 32'(errs), 0);

    // Granted host read while idle
    @(posedge clk); #1;
    bus.host_req_i  = 1'b1;
    bus.host_addr_i = 12'd2399;
    @(negedge clk);
    check("idle_gnt", 32'(bus.host_gnt_o), 1);
    @(posedge clk); #1;
    bus.host_req_i = 1'b0;
    @(negedge clk);
    check("idle_rvalid", 32'(bus.host_rvalid_o), 1);
    check("idle_rdata", {bus.host_ch_o, bus.host_col_o}, 32'h2E70);

    // Reset during the fill phase of a clear
    begin
      int d;
      plan_cmd(1'b0, 0, 8'h11, 8'h22, d);
    end
    accept_cmd(1'b0, 0, 8'h11, 8'h22);
    repeat (200) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_wen", 32'(bus.map_wen_o), 0);
    check("mid_rst_busy", 32'(bus.busy_o), 0);
    check("mid_rst_ready", 32'(bus.cmd_ready_o), 1);
    check("mid_rst_addr", 32'(bus.map_addr_o), 0);
    check("mid_rst_fill_progress", 32'(mem[150]), 32'h1122);
    wr_q.delete();
    w_snap = n_writes;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_ready", 32'(bus.cmd_ready_o), 1);
    check("post_rst_busy", 32'(bus.busy_o), 0);
    check("post_rst_no_writes", 32'(n_writes - w_snap), 0);
    check("post_rst_untouched", 32'(mem[2399]), 32'h2E70);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
